// File: rtl/soc_uart_readback.sv
// UART-side memory read bridge: takes an 8-byte read command, fetches words over the
// SoC bus and streams them back with a status byte and trailing CRC-32.
module soc_uart_readback #(
  parameter logic [31:0] MAX_WORDS = 32'd65536
) (
  input  logic        clk,
  input  logic        res,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        rx_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_write_en,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_read_data,
  input  logic        mem_valid
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [7:0]  ST_OK    = 8'h59;
  localparam logic [7:0]  ST_ERR   = 8'hE0;

  typedef enum logic [2:0] {S_HDR, S_STAT, S_MEM, S_TXD, S_TXC, S_ERR} state_t;

  state_t      state_q;
  logic [2:0]  ptr_q;
  logic [55:0] hdr_q;
  logic [31:0] cnt_q;
  logic        reject_q;
  logic [31:0] word_q;
  logic [1:0]  bidx_q;
  logic [31:0] crc_q;
  logic        rx_ready_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_req_q;

  logic [63:0] hdr_full;
  logic [31:0] hdr_cnt;
  logic [31:0] crc_d;
  logic [31:0] cnt_dec;
  logic        rx_hs;
  logic        tx_hs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_comb begin
    hdr_full = {rx_data, hdr_q};
    hdr_cnt  = (hdr_full[63:32] == 32'd0) ? 32'd1 : hdr_full[63:32];
    crc_d    = crc_byte(crc_q, tx_data_q);
    cnt_dec  = cnt_q - 32'd1;
    rx_hs    = rx_valid && rx_ready_q;
    tx_hs    = tx_valid_q && tx_ready;
  end

  // rx_error pre-empts every state but ERROR; reset pre-empts everything
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= S_HDR;
      ptr_q      <= 3'd0;
      hdr_q      <= 56'd0;
      cnt_q      <= 32'd0;
      reject_q   <= 1'b0;
      word_q     <= 32'd0;
      bidx_q     <= 2'd0;
      crc_q      <= CRC_INIT;
      rx_ready_q <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_req_q  <= 1'b0;
    end else if (rx_error && state_q != S_ERR) begin
      state_q    <= S_ERR;
      mem_req_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b1;
      tx_data_q  <= ST_ERR;
    end else begin
      case (state_q)
        S_HDR: begin
          rx_ready_q <= 1'b1;
          if (rx_hs) begin
            hdr_q <= {rx_data, hdr_q[55:8]};
            ptr_q <= ptr_q + 3'd1;
            if (ptr_q == 3'd7) begin
              rx_ready_q <= 1'b0;
              cnt_q      <= hdr_cnt;
              reject_q   <= (hdr_cnt > MAX_WORDS);
              tx_valid_q <= 1'b1;
              tx_data_q  <= (hdr_cnt > MAX_WORDS) ? ST_ERR : ST_OK;
              if (hdr_cnt <= MAX_WORDS) mem_addr_q <= hdr_full[31:0] & 32'hFFFF_FFFC;
              state_q    <= S_STAT;
            end
          end
        end
        S_STAT: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            if (reject_q) begin
              state_q <= S_HDR;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= S_MEM;
            end
          end
        end
        S_MEM: begin
          if (mem_valid) begin
            word_q     <= mem_read_data;
            mem_req_q  <= 1'b0;
            bidx_q     <= 2'd0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= mem_read_data[7:0];
            state_q    <= S_TXD;
          end
        end
        S_TXD: begin
          if (tx_hs) begin
            crc_q <= crc_d;
            if (bidx_q == 2'd3) begin
              cnt_q  <= cnt_dec;
              bidx_q <= 2'd0;
              if (cnt_dec != 32'd0) begin
                tx_valid_q <= 1'b0;
                mem_addr_q <= mem_addr_q + 32'd4;
                mem_req_q  <= 1'b1;
                state_q    <= S_MEM;
              end else begin
                tx_data_q <= ~crc_d[7:0];
                state_q   <= S_TXC;
              end
            end else begin
              bidx_q    <= bidx_q + 2'd1;
              tx_data_q <= byte_sel(word_q, bidx_q + 2'd1);
            end
          end
        end
        S_TXC: begin
          if (tx_hs) begin
            if (bidx_q == 2'd3) begin
              crc_q      <= CRC_INIT;
              tx_valid_q <= 1'b0;
              bidx_q     <= 2'd0;
              state_q    <= S_HDR;
            end else begin
              bidx_q    <= bidx_q + 2'd1;
              tx_data_q <= byte_sel(~crc_q, bidx_q + 2'd1);
            end
          end
        end
        default: begin
          rx_ready_q <= 1'b0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= ST_ERR;
        end
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_req      = mem_req_q;
  assign mem_write_en = 1'b0;
  assign mem_byte_en  = 4'b1111;

endmodule

// File: tb/tb_soc_uart_readback.sv
// Self-checking bench for soc_uart_readback against a queue-based response model.
module tb_soc_uart_readback;

  localparam logic [31:0] MAXW = 32'd65536;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_error = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_write_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_read_data = 32'd0;
  logic        mem_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  got[$];
  logic [7:0]  saved[$];
  logic [7:0]  exp_q[$];
  logic [31:0] addrq[$];
  logic [31:0] expa_q[$];
  int          req_edges = 0;
  bit          stall_on = 1'b0;
  bit          mem_hold = 1'b0;
  int          mem_dly_max = 0;
  bit          held = 1'b0;
  logic [7:0]  held_data = 8'd0;
  bit          prev_req = 1'b0;

  soc_uart_readback #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .res(res),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_error(rx_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .mem_byte_en(mem_byte_en), .mem_read_data(mem_read_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00000000;
      32'h200: return 32'h11223344;
      32'h204: return 32'h55667788;
      32'h208: return 32'h99AABBCC;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      r = ((r[0] ^ b[k]) != 1'b0) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Expected tx byte stream and read-address sequence for one command
  task automatic build_exp(input logic [31:0] addr, input logic [31:0] cnt);
    logic [31:0] n, a, w, crc;
    exp_q.delete();
    expa_q.delete();
    n = (cnt == 0) ? 32'd1 : cnt;
    if (n > MAXW) begin
      exp_q.push_back(8'hE0);
      return;
    end
    exp_q.push_back(8'h59);
    a = {addr[31:2], 2'b00};
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < int'(n); i++) begin
      expa_q.push_back(a);
      w = mem_word(a);
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(w[8*j +: 8]);
        crc = crc_upd(crc, w[8*j +: 8]);
      end
      a = a + 32'd4;
    end
    crc = ~crc;
    for (int j = 0; j < 4; j++) exp_q.push_back(crc[8*j +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] cnt);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(cnt[8*i +: 8]);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
    int n;
    build_exp(addr, cnt);
    got.delete();
    addrq.delete();
    req_edges = 0;
    send_cmd(addr, cnt);
    for (int i = 0; i < 20000 && got.size() < exp_q.size(); i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_nreq"}, 32'(req_edges), 32'(expa_q.size()));
    check({tag, "_naddr"}, 32'(addrq.size()), 32'(expa_q.size()));
    n = (addrq.size() < expa_q.size()) ? addrq.size() : expa_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_addr%0d", tag, i), addrq[i], expa_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  // Memory responder: random latency, one-cycle mem_valid
  initial begin
    int wait_c;
    wait_c = -1;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) mem_valid = 1'b0;
      else if (!mem_req || mem_hold) wait_c = -1;
      else begin
        if (wait_c < 0) wait_c = $urandom_range(0, mem_dly_max);
        if (wait_c == 0) begin
          mem_valid = 1'b1;
          mem_read_data = mem_word(mem_addr);
          addrq.push_back(mem_addr);
          wait_c = -1;
        end else wait_c--;
      end
    end
  end

  // UART tx side: optional random back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = !stall_on || ($urandom_range(0, 2) == 0);
    end
  end

  // Byte capture, tx stability and mem_req edge counting, mid-cycle
  always @(negedge clk) begin
    if (!res) begin
      held = 1'b0;
    end else begin
      if (tx_valid && held) check("tx_stable", 32'(tx_data), 32'(held_data));
      if (tx_valid && tx_ready) got.push_back(tx_data);
      held = tx_valid && !tx_ready;
      held_data = tx_data;
    end
    if (mem_req && !prev_req) req_edges++;
    prev_req = mem_req;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  g1[9];
    logic [31:0] ra, rc;
    int n;
    g1 = '{8'h59, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'hDF, 8'h44, 8'h21};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check("wr_en", 32'(mem_write_en), 32'd0);
    check("byte_en", 32'(mem_byte_en), 32'hF);
    @(posedge clk);
    #1;
    res = 1'b1;

    run_cmd("single", 32'h100, 32'd1);
    n = (got.size() < 9) ? got.size() : 9;
    for (int i = 0; i < n; i++) check($sformatf("golden%0d", i), 32'(got[i]), 32'(g1[i]));

    run_cmd("three", 32'h203, 32'd3);

    run_cmd("cnt1", 32'h0, 32'd1);
    saved = got;
    run_cmd("cnt0", 32'h0, 32'd0);
    check("cnt0_vs_cnt1_len", 32'(got.size()), 32'(saved.size()));
    n = (got.size() < saved.size()) ? got.size() : saved.size();
    for (int i = 0; i < n; i++) check($sformatf("cnt0_vs_cnt1_%0d", i), 32'(got[i]), 32'(saved[i]));

    run_cmd("reject", 32'h10, MAXW + 32'd1);
    run_cmd("after_reject", 32'h40, 32'd2);

    ra = $urandom & 32'h000F_FFFC;
    run_cmd("nostall", ra, 32'd4);
    saved = got;
    stall_on = 1'b1;
    mem_dly_max = 10;
    run_cmd("stall", ra, 32'd4);
    check("stall_vs_nostall_len", 32'(got.size()), 32'(saved.size()));
    n = (got.size() < saved.size()) ? got.size() : saved.size();
    for (int i = 0; i < n; i++) check($sformatf("stall_vs_nostall_%0d", i), 32'(got[i]), 32'(saved[i]));

    run_cmd("wrap", 32'hFFFF_FFFC, 32'd2);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rc = $urandom_range(0, 5);
      run_cmd($sformatf("rand%0d", k), ra, rc);
    end

    // rx_error while waiting on memory
    stall_on = 1'b0;
    mem_hold = 1'b1;
    send_cmd(32'h300, 32'd4);
    for (int i = 0; i < 200 && !mem_req; i++) @(negedge clk);
    check("err_req_seen", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rx_error = 1'b1;
    @(posedge clk);
    #1;
    rx_error = 1'b0;
    @(negedge clk);
    check("err_mem_req", 32'(mem_req), 32'd0);
    check("err_rx_ready", 32'(rx_ready), 32'd0);
    check("err_tx_valid", 32'(tx_valid), 32'd1);
    check("err_tx_data", 32'(tx_data), 32'hE0);
    got.delete();
    repeat (6) @(posedge clk);
    #1;
    check("err_repeat_cnt", 32'(got.size() >= 5), 32'd1);
    foreach (got[i]) check($sformatf("err_byte%0d", i), 32'(got[i]), 32'hE0);
    check("err_rx_ready_late", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst2");
    @(posedge clk);
    #1;
    run_cmd("post_reset", 32'h200, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_uart_readback.md
Name: soc_uart_readback

Overview:
- UART-side memory read bridge, the read counterpart of the UART programming bridge.
- Receives a read command (address, word count) as a byte stream, fetches words over the SoC memory bus, and streams them back followed by a CRC-32 over the payload.
- Sits between the byte-level UART core (clk-domain byte handshake) and the SoC memory bus; used by the host script to verify programmed images.

Parameters:
- MAX_WORDS, 32'd65536, largest accepted word count; larger requests are rejected.

Ports:
- clk  in  1  system clock
- res  in  1  reset, synchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte consumed when rx_valid && rx_ready
- rx_error  in  1  UART overrun/break flag, level
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte when tx_valid && tx_ready
- mem_addr  out  32  word-aligned read address
- mem_req  out  1  memory request
- mem_write_en  out  1  constant 0
- mem_byte_en  out  4  constant 4'b1111
- mem_read_data  in  32  read data, sampled when mem_valid
- mem_valid  in  1  transaction complete

Behaviour:
- Reset (res==0 at posedge clk): rx_ready=0, tx_valid=0, tx_data=0, mem_req=0, mem_addr=0, CRC=32'hFFFFFFFF, word counter=0, byte pointer=0, state=HDR. res has priority over every other event, including mid-transfer; the in-flight memory request is dropped.
- Command format: 8 bytes, little-endian: ADDR[31:0], then COUNT[31:0] (words).
- HDR:
  - rx_ready=1; shift in bytes; byte pointer 0..7.
  - ADDR bits [1:0] are forced to 0.
  - COUNT==0 is treated as 1.
  - After the 8th byte, rx_ready drops the next cycle.
  - If COUNT > MAX_WORDS: send 8'hE0 once, then return to HDR.
  - Otherwise: send 8'h59, then go to MEM.
- MEM:
  - mem_req=1 with mem_addr held until the cycle mem_valid=1.
  - That cycle: latch mem_read_data, deassert mem_req, go to TXD.
  - Any number of wait cycles is allowed.
- TXD:
  - Send the 4 latched bytes LSB first; each byte is fed to the CRC when accepted (tx_valid && tx_ready).
  - tx_valid stays high with tx_data stable until accepted.
  - After the 4th byte: decrement the counter.
  - If the counter is still nonzero: mem_addr += 4 (wraps modulo 2^32), go to MEM.
  - Else go to TXC.
- TXC:
  - Send ~CRC as 4 bytes, LSB first.
  - Then reset CRC to FFFFFFFF, go to HDR.
- CRC-32 definition: reflected, poly 32'hEDB88320, init FFFFFFFF, final XOR FFFFFFFF. Covers payload bytes only, not the status byte. Updated in one cycle per accepted byte.
- rx_ready=0 in all states except HDR. Host bytes arriving during a response are held off by the UART core, never dropped by this block.
- rx_error:
  - Sampled in every state except ERROR.
  - When high, go to ERROR; mem_req is deasserted immediately even if mem_valid has not arrived.
  - ERROR: tx_data=8'hE0, tx_valid=1 continuously, rx_ready=0. Exit only via reset.
  - If rx_error is high in the same cycle as a byte handshake, the error wins and the byte is discarded.
- Throughput: one status byte or data byte per accepted handshake, with no bubble between bytes within a word. At most 2 idle cycles between the last byte of a word and mem_req for the next.

Test Plan:
- Cmd 00 01 00 00 | 01 00 00 00, memory[0x100]=0x00000000 → tx: 59 00 00 00 00 1C DF 44 21; mem_addr=0x100, exactly one mem_req.
- Cmd addr 0x00000203, COUNT=3, memory 0x200/0x204/0x208 = 0x11223344/0x55667788/0x99AABBCC → mem_addr sequence 0x200, 0x204, 0x208; payload 44 33 22 11 88 77 66 55 CC BB AA 99; trailing CRC matches a golden model.
- COUNT=0 at addr 0x0 → identical response to COUNT=1. COUNT=MAX_WORDS+1 → single E0, no mem_req; a following valid command is served normally.
- Random tx_ready stalls (0–5 cycles) and mem_valid delays (0–10 cycles) during COUNT=4 → byte stream identical to the no-stall run; tx_data stable while tx_valid && !tx_ready.
- rx_error pulse while in MEM → mem_req low next cycle; E0 repeated on every tx handshake; rx_ready=0; res=0 for one cycle then returns to HDR with all outputs at reset values.
- Addr 0xFFFFFFFC, COUNT=2 → second read at 0x00000000 (wrap-around).
